// File: rtl/cb_op_sequencer_pkg.sv
// Shared constants for the CB-prefix sequencer: ALU control-word codes,
// CB opcode field positions, the (HL) register index and an opcode
// classifier used by the sequencer's decode step.
package cb_op_sequencer_pkg;

    // ALU function select codes (shared control-word constants)
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_BIT  = 5'b01000;
    localparam logic [4:0] ALU_RL   = 5'b01001;
    localparam logic [4:0] ALU_SWAP = 5'b01101;
    localparam logic [4:0] ALU_RES  = 5'b01111;

    // CB opcode field positions: [7:6] group, [5:3] bit/sub-op, [2:0] register
    localparam int CB_REG_LSB = 0;
    localparam int CB_BIT_LSB = 3;
    localparam int CB_GRP_LSB = 6;

    // Register index that selects the memory operand at HL
    localparam logic [2:0] REG_HL = 3'b110;

    // Returns the ALU code for a supported CB opcode, ALU_NONE otherwise.
    function automatic logic [4:0] cb_alu_code(input logic [7:0] opc);
        logic [1:0] grp;
        logic [2:0] sub;
        grp = opc[CB_GRP_LSB +: 2];
        sub = opc[CB_BIT_LSB +: 3];
        case (grp)
            2'b01:   cb_alu_code = ALU_BIT;
            2'b10:   cb_alu_code = ALU_RES;
            2'b00:   cb_alu_code = (sub == 3'b010) ? ALU_RL   :
                                   (sub == 3'b110) ? ALU_SWAP : ALU_NONE;
            default: cb_alu_code = ALU_NONE;   // SET group
        endcase
    endfunction

endpackage

// File: rtl/cb_wait_timer.sv
// Wait counter for the memory handshake states.
// Ports: clk4_2/reset_n clock and async active-low reset; i_clr zeroes the
// count; i_en advances it; o_expired is high when the count has reached
// MEM_TIMEOUT-1 (the last permitted wait cycle).
module cb_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8
) (
    input  logic clk4_2,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT - 1);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/cb_op_sequencer.sv
// Multi-cycle controller that sequences the shared ALU for CB-prefixed
// instructions, with register write-back or an (HL) read/modify/write over
// a req/ack bus handshake.
// Ports: clk4_2, reset_n (async, active-low); i_start/i_cb_opcode request;
// i_mem_ack bus completion; o_busy, o_reg_sel, o_alu_out_wr, o_alu_cntl,
// o_bit_op, o_reg_wr, o_mem_rd_req, o_mem_wr_req, o_done, o_err.
// All outputs are registered and decoded from the next state, so they line
// up exactly with the state they belong to.
module cb_op_sequencer
    import cb_op_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8
) (
    input  logic       clk4_2,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [7:0] i_cb_opcode,
    input  logic       i_mem_ack,
    output logic       o_busy,
    output logic [2:0] o_reg_sel,
    output logic       o_alu_out_wr,
    output logic [4:0] o_alu_cntl,
    output logic [2:0] o_bit_op,
    output logic       o_reg_wr,
    output logic       o_mem_rd_req,
    output logic       o_mem_wr_req,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_MEM_WR = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_nxt;
    logic [7:0] r_opc;
    logic [4:0] w_code;
    logic       w_is_hl;
    logic       w_in_mem;
    logic       w_expired;

    logic       r_busy, r_alu_out_wr, r_reg_wr, r_mem_rd_req, r_mem_wr_req;
    logic       r_done, r_err;
    logic [4:0] r_alu_cntl;

    assign w_code   = cb_alu_code(r_opc);
    assign w_is_hl  = (r_opc[CB_REG_LSB +: 3] == REG_HL);
    assign w_in_mem = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // Counter is held at zero outside the memory states, so every entry
    // into MEM_RD or MEM_WR starts counting from zero.
    cb_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_wait_timer (
        .clk4_2    (clk4_2),
        .reset_n   (reset_n),
        .i_clr     (!w_in_mem),
        .i_en      (w_in_mem && !i_mem_ack),
        .o_expired (w_expired)
    );

    // An ack on the limit cycle takes priority over the timeout.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_nxt = S_DECODE;
            S_DECODE: w_nxt = (w_code == ALU_NONE) ? S_ERR    :
                              w_is_hl              ? S_MEM_RD : S_EXEC;
            S_MEM_RD: if (i_mem_ack)      w_nxt = S_EXEC;
                      else if (w_expired) w_nxt = S_ERR;
            S_EXEC:   w_nxt = (w_code == ALU_BIT) ? S_DONE   :
                              w_is_hl             ? S_MEM_WR : S_WB;
            S_WB:     w_nxt = S_DONE;
            S_MEM_WR: if (i_mem_ack)      w_nxt = S_DONE;
                      else if (w_expired) w_nxt = S_ERR;
            default:  w_nxt = S_IDLE;   // DONE, ERR
        endcase
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_opc        <= 8'h00;
            r_busy       <= 1'b0;
            r_alu_out_wr <= 1'b0;
            r_alu_cntl   <= ALU_NONE;
            r_reg_wr     <= 1'b0;
            r_mem_rd_req <= 1'b0;
            r_mem_wr_req <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IDLE && i_start) r_opc <= i_cb_opcode;
            r_busy       <= (w_nxt != S_IDLE);
            r_alu_out_wr <= (w_nxt == S_EXEC);
            // Function select is only driven while the ALU is strobed.
            r_alu_cntl   <= (w_nxt == S_EXEC) ? w_code : ALU_NONE;
            r_reg_wr     <= (w_nxt == S_WB);
            r_mem_rd_req <= (w_nxt == S_MEM_RD);
            r_mem_wr_req <= (w_nxt == S_MEM_WR);
            r_done       <= (w_nxt == S_DONE) || (w_nxt == S_ERR);
            r_err        <= (w_nxt == S_ERR);
        end
    end

    assign o_busy       = r_busy;
    assign o_reg_sel    = r_opc[CB_REG_LSB +: 3];
    assign o_bit_op     = r_opc[CB_BIT_LSB +: 3];
    assign o_alu_out_wr = r_alu_out_wr;
    assign o_alu_cntl   = r_alu_cntl;
    assign o_reg_wr     = r_reg_wr;
    assign o_mem_rd_req = r_mem_rd_req;
    assign o_mem_wr_req = r_mem_wr_req;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
